// File: rtl/morty_pipe_pkg.sv
// -----------------------------------------------------------------------------
// morty_pipe_pkg
//   Shared definitions for the morty pipeline-stage register.
//   - pipe_state_e : stage occupancy state. The encoding equals the item
//                    count, so occupancy_o is the state register itself.
//                    The hazard unit reads occupancy_o against these values.
//   - EXC_NONE     : exception code meaning "no exception".
//   - slot_ctrl_t  : per-cycle load/clear controls for the main and skid slots.
//   - state_occupancy() : state -> occupancy count.
// -----------------------------------------------------------------------------
package morty_pipe_pkg;

    localparam int OCC_W    = 2;
    localparam int EXC_NONE = 0;

    // Encoding doubles as the item count held by the stage.
    typedef enum logic [OCC_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    // Slot controls decoded from the state and the handshake each cycle.
    typedef struct packed {
        logic main_load;       // write the main slot this cycle
        logic main_from_skid;  // main slot source: 1 = skid slot, 0 = input
        logic skid_load;       // write the input into the skid slot
        logic skid_clear;      // zero the skid slot
    } slot_ctrl_t;

    function automatic logic [OCC_W-1:0] state_occupancy(input pipe_state_e s);
        return OCC_W'(s);
    endfunction

endpackage

// File: rtl/morty_pipe_slot.sv
// -----------------------------------------------------------------------------
// morty_pipe_slot
//   One storage entry of a pipeline stage: a W-bit register holding
//   {exception code, payload}. Priority: reset > clear > load > hold.
//
// Ports
//   i_clk    in   1  rising-edge clock
//   i_rst_n  in   1  synchronous reset, active-low; zeroes the entry
//   i_clear  in   1  zero the entry (flush or drained skid)
//   i_load   in   1  capture i_d
//   i_d      in   W  next entry value
//   o_q      out  W  current entry value
// -----------------------------------------------------------------------------
module morty_pipe_slot
    import morty_pipe_pkg::*;
#(
    parameter int W = 100
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/morty_pipe_stage.sv
// -----------------------------------------------------------------------------
// morty_pipe_stage
//   Parametrised pipeline-stage register with a valid/ready handshake, an
//   optional second (skid) entry, flush, and an exception code that travels
//   atomically with each payload.
//
//   Handshake:
//     accept  = in_valid_i  & in_ready_o          (item enters the stage)
//     consume = out_valid_o & out_ready_i & ~stall_i  (item leaves the stage)
//   Both sides transfer only on the rising edge where the condition holds;
//   a producer holds data stable while valid is high and not yet accepted.
//
// Parameters
//   DATA_W  payload width
//   EXC_W   exception-code width (>= 1), zero code = no exception
//   SKID    1: two entries, in_ready_o depends only on the state register
//           0: one entry, in_ready_o also opens on a same-cycle consume
//
// Ports
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous reset, active-low
//   flush_i      in   1       empty the stage; beats stall/accept/consume
//   stall_i      in   1       freeze held entries; consume suppressed
//   in_valid_i   in   1       upstream offers in_data_i/in_exc_i
//   in_ready_o   out  1       stage can accept this cycle
//   in_data_i    in   DATA_W  payload
//   in_exc_i     in   EXC_W   exception code
//   out_valid_o  out  1       main entry holds a valid item
//   out_ready_i  in   1       downstream accepts
//   out_data_o   out  DATA_W  main-entry payload
//   out_exc_o    out  EXC_W   main-entry exception code
//   occupancy_o  out  2       items held (0, 1, 2); also the FSM state
// -----------------------------------------------------------------------------
module morty_pipe_stage
    import morty_pipe_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int EXC_W  = 4,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [EXC_W-1:0]  in_exc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [EXC_W-1:0]  out_exc_o,
    output logic [OCC_W-1:0]  occupancy_o
);

    localparam int SLOT_W = DATA_W + EXC_W;

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;

    logic              w_out_valid;
    logic              w_consume;
    logic              w_in_ready;
    logic              w_accept;
    slot_ctrl_t        w_ctrl;

    logic [SLOT_W-1:0] w_in_slot;
    logic [SLOT_W-1:0] w_main_d;
    logic [SLOT_W-1:0] w_main_q;
    logic [SLOT_W-1:0] w_skid_q;

    // Exception code sits in the upper bits so it always moves with its payload.
    assign w_in_slot = {in_exc_i, in_data_i};

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs and slot controls decoded from the state
    // -------------------------------------------------------------------------
    always_comb begin
        w_out_valid = (r_state != ST_EMPTY);
        w_consume   = w_out_valid & out_ready_i & ~stall_i;

        // rst gates ready so nothing is offered while the stage is held in
        // reset. With a skid entry the ready is a pure state decode, so no
        // combinational path exists from out_ready_i or stall_i.
        if (SKID != 0) begin
            w_in_ready = rst & (r_state != ST_TWO);
        end else begin
            w_in_ready = rst & ((r_state == ST_EMPTY) | w_consume);
        end

        w_accept = in_valid_i & w_in_ready;

        w_ctrl = '0;
        unique case (r_state)
            ST_EMPTY: begin
                // Accepting into an empty stage is allowed even while stalled.
                w_ctrl.main_load = w_accept;
            end
            ST_ONE: begin
                // Simultaneous accept and consume replaces main directly;
                // accept without consume parks the new item in the skid slot.
                w_ctrl.main_load = w_accept & w_consume;
                w_ctrl.skid_load = w_accept & ~w_consume;
            end
            ST_TWO: begin
                // Skid drains into main; the vacated skid entry is zeroed.
                w_ctrl.main_load      = w_consume;
                w_ctrl.main_from_skid = 1'b1;
                w_ctrl.skid_clear     = w_consume;
            end
            default: begin
                w_ctrl = '0;
            end
        endcase

        // Flush zeroes both entries; the slot's clear beats its load, so any
        // same-cycle accept is dropped.
        if (flush_i) begin
            w_ctrl.skid_clear = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_consume) begin
                        // Unreachable without a skid entry: ready is only
                        // high in ONE when the held item is leaving.
                        if (SKID != 0) begin
                            w_state_nxt = ST_TWO;
                        end
                    end else if (!w_accept && w_consume) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_consume) begin
                        w_state_nxt = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    assign w_main_d = w_ctrl.main_from_skid ? w_skid_q : w_in_slot;

    morty_pipe_slot #(
        .W (SLOT_W)
    ) u_main_slot (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clear (flush_i),
        .i_load  (w_ctrl.main_load),
        .i_d     (w_main_d),
        .o_q     (w_main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            morty_pipe_slot #(
                .W (SLOT_W)
            ) u_skid_slot (
                .i_clk   (clk),
                .i_rst_n (rst),
                .i_clear (w_ctrl.skid_clear),
                .i_load  (w_ctrl.skid_load),
                .i_d     (w_in_slot),
                .o_q     (w_skid_q)
            );
        end else begin : g_no_skid
            assign w_skid_q = '0;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs. After a consume empties the stage the main slot keeps its last
    // value; consumers qualify on out_valid_o.
    // -------------------------------------------------------------------------
    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign out_data_o  = w_main_q[DATA_W-1:0];
    assign out_exc_o   = w_main_q[SLOT_W-1:DATA_W];
    assign occupancy_o = state_occupancy(r_state);

endmodule

// File: tb/tb_morty_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_morty_pipe_stage
//   Instance 0: SKID=1, instance 1: SKID=0, both DATA_W=96, EXC_W=4.
//   A queue-level model (item count + FIFO of up to two items + last shown
//   item) predicts every output each cycle; directed literal checks pin the
//   model; a scoreboard compares drained items against an expected queue.
// -----------------------------------------------------------------------------
module tb_morty_pipe_stage;

    localparam int DW = 96;
    localparam int EW = 4;
    localparam int IW = DW + EW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    flush, stall, in_valid, out_ready;
    logic [1:0]    in_ready, out_valid;
    logic [DW-1:0] in_data  [2];
    logic [EW-1:0] in_exc   [2];
    logic [DW-1:0] out_data [2];
    logic [EW-1:0] out_exc  [2];
    logic [1:0]    occ      [2];

    morty_pipe_stage #(.DATA_W(DW), .EXC_W(EW), .SKID(1)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush[0]),
        .stall_i     (stall[0]),
        .in_valid_i  (in_valid[0]),
        .in_ready_o  (in_ready[0]),
        .in_data_i   (in_data[0]),
        .in_exc_i    (in_exc[0]),
        .out_valid_o (out_valid[0]),
        .out_ready_i (out_ready[0]),
        .out_data_o  (out_data[0]),
        .out_exc_o   (out_exc[0]),
        .occupancy_o (occ[0])
    );

    morty_pipe_stage #(.DATA_W(DW), .EXC_W(EW), .SKID(0)) u_noskid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush[1]),
        .stall_i     (stall[1]),
        .in_valid_i  (in_valid[1]),
        .in_ready_o  (in_ready[1]),
        .in_data_i   (in_data[1]),
        .in_exc_i    (in_exc[1]),
        .out_valid_o (out_valid[1]),
        .out_ready_i (out_ready[1]),
        .out_data_o  (out_data[1]),
        .out_exc_o   (out_exc[1]),
        .occupancy_o (occ[1])
    );

    // ---------------- checking core ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: m_cnt items held, m_buf FIFO (index 0 = shown item),
    // m_hold = what out_data/out_exc show (last shown item, zero after reset/flush).
    logic [IW-1:0] m_buf  [2][2];
    logic [IW-1:0] m_hold [2];
    int            m_cnt  [2];
    bit            live = 1'b0;

    function automatic logic m_consume(input int k);
        return (m_cnt[k] > 0) && out_ready[k] && !stall[k];
    endfunction

    function automatic logic m_ready(input int k);
        if (!rst) return 1'b0;
        if (k == 0) return m_cnt[0] < 2;
        return (m_cnt[1] == 0) || m_consume(1);
    endfunction

    initial begin
        logic acc;
        logic con;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_hold[k] = '0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                acc = in_valid[k] && m_ready(k);
                con = m_consume(k);
                if (!rst || flush[k]) begin
                    m_cnt[k]  = 0;
                    m_hold[k] = '0;
                end else begin
                    if (con) begin
                        m_buf[k][0] = m_buf[k][1];
                        m_cnt[k]    = m_cnt[k] - 1;
                    end
                    if (acc) begin
                        m_buf[k][m_cnt[k]] = {in_exc[k], in_data[k]};
                        m_cnt[k]           = m_cnt[k] + 1;
                    end
                    if (m_cnt[k] > 0) m_hold[k] = m_buf[k][0];
                end
            end
            if (!rst) live = 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] got0_q[$];
    logic [IW-1:0] got1_q[$];

    // Per-cycle compare against the model, plus capture of consumed items.
    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("model occ[%0d]", k), IW'(occ[k]), IW'(m_cnt[k]));
                    chk($sformatf("model valid[%0d]", k), IW'(out_valid[k]), IW'(m_cnt[k] > 0));
                    chk($sformatf("model data[%0d]", k), IW'(out_data[k]), IW'(m_hold[k][DW-1:0]));
                    chk($sformatf("model exc[%0d]", k), IW'(out_exc[k]), IW'(m_hold[k][IW-1:DW]));
                    chk($sformatf("model ready[%0d]", k), IW'(in_ready[k]), IW'(m_ready(k)));
                    if (rst && !flush[k] && out_valid[k] && out_ready[k] && !stall[k]) begin
                        if (k == 0) got0_q.push_back({out_exc[k], out_data[k]});
                        else        got1_q.push_back({out_exc[k], out_data[k]});
                    end
                end
            end
        end
    end

    task automatic chk_drain(input int k, input string name);
        logic [IW-1:0] g[$];
        if (k == 0) g = got0_q;
        else        g = got1_q;
        chk({name, " count"}, IW'(g.size()), IW'(exp_q.size()));
        for (int i = 0; i < g.size() && i < exp_q.size(); i++)
            chk($sformatf("%s item%0d", name, i), g[i], exp_q[i]);
        exp_q.delete();
        got0_q.delete();
        got1_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Called at posedge+1; holds the item until a cycle with in_ready high.
    task automatic push(input int k, input logic [DW-1:0] d, input logic [EW-1:0] e);
        bit done;
        done        = 1'b0;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_exc[k]   = e;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (in_ready[k] === 1'b1) done = 1'b1;
            step();
        end
        in_valid[k] = 1'b0;
        if (!done) begin
            n_chk++;
            $display("FAIL push_timeout[%0d]: data %0h never accepted within 40 cycles", k, d);
        end
    endtask

    // Hard stop if anything ever hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; flush = '0; stall = '0; in_valid = '0; out_ready = '0;
        for (int k = 0; k < 2; k++) begin
            in_data[k] = '0;
            in_exc[k]  = '0;
        end

        // Reset state
        step();
        @(negedge clk);
        chk("rst ready0", IW'(in_ready[0]), IW'(0));
        chk("rst ready1", IW'(in_ready[1]), IW'(0));
        chk("rst occ0",   IW'(occ[0]),      IW'(0));
        chk("rst valid0", IW'(out_valid[0]), IW'(0));
        chk("rst data0",  IW'(out_data[0]), IW'(0));
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("post rst ready0", IW'(in_ready[0]), IW'(1));
        chk("post rst ready1", IW'(in_ready[1]), IW'(1));
        step();

        // 1: streaming 0x1..0x8 with out_ready=1
        out_ready[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back({4'h0, DW'(i)});
            push(0, DW'(i), 4'h0);
        end
        @(negedge clk);
        chk("t1 last data", IW'(out_data[0]), IW'(8));
        chk("t1 occ",       IW'(occ[0]),      IW'(1));
        idle(3);
        chk_drain(0, "t1 order");

        // 2: back-pressure for 3 cycles
        out_ready[0] = 1'b0;
        push(0, DW'('hA1), 4'h0);
        push(0, DW'('hB2), 4'h0);
        in_valid[0] = 1'b1;
        in_data[0]  = DW'('hC3);
        @(negedge clk);
        chk("t2 occ two",  IW'(occ[0]),      IW'(2));
        chk("t2 ready lo", IW'(in_ready[0]), IW'(0));
        chk("t2 main A",   IW'(out_data[0]), IW'('hA1));
        step();
        out_ready[0] = 1'b1;
        push(0, DW'('hC3), 4'h0);
        idle(4);
        exp_q.push_back(IW'('hA1));
        exp_q.push_back(IW'('hB2));
        exp_q.push_back(IW'('hC3));
        chk_drain(0, "t2 order");

        // 3: flush in TWO with a 0xDEAD offer
        out_ready[0] = 1'b0;
        push(0, DW'('h11), 4'h0);
        push(0, DW'('h22), 4'h0);
        flush[0]    = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = DW'('hDEAD);
        step();
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("t3 valid", IW'(out_valid[0]), IW'(0));
        chk("t3 occ",   IW'(occ[0]),       IW'(0));
        chk("t3 data",  IW'(out_data[0]),  IW'(0));
        step();
        out_ready[0] = 1'b1;
        idle(3);
        chk_drain(0, "t3 nothing out");

        // 4: stall in ONE with out_ready=1, accept 0x5 into skid
        out_ready[0] = 1'b0;
        push(0, DW'('h4), 4'h0);
        out_ready[0] = 1'b1;
        stall[0]     = 1'b1;
        push(0, DW'('h5), 4'h0);
        @(negedge clk);
        chk("t4 occ",       IW'(occ[0]),      IW'(2));
        chk("t4 main held", IW'(out_data[0]), IW'('h4));
        step();
        @(negedge clk);
        chk("t4 still held", IW'(out_data[0]), IW'('h4));
        step();
        stall[0] = 1'b0;
        idle(3);
        exp_q.push_back(IW'('h4));
        exp_q.push_back(IW'('h5));
        chk_drain(0, "t4 order");

        // 5: exception code travels with 0x9 only
        push(0, DW'('h8), 4'h0);
        push(0, DW'('h9), 4'h3);
        @(negedge clk);
        chk("t5 data 9", IW'(out_data[0]), IW'('h9));
        chk("t5 exc 3",  IW'(out_exc[0]),  IW'('h3));
        step();
        push(0, DW'('hA), 4'h0);
        @(negedge clk);
        chk("t5 exc after", IW'(out_exc[0]), IW'(0));
        step();
        idle(2);
        exp_q.push_back({4'h0, DW'('h8)});
        exp_q.push_back({4'h3, DW'('h9)});
        exp_q.push_back({4'h0, DW'('hA)});
        chk_drain(0, "t5 exc order");

        // 6: reset while in TWO
        out_ready[0] = 1'b0;
        push(0, DW'('h31), 4'h1);
        push(0, DW'('h32), 4'h2);
        rst = 1'b0;
        @(negedge clk);
        chk("t6 ready in rst", IW'(in_ready[0]), IW'(0));
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t6 valid", IW'(out_valid[0]), IW'(0));
        chk("t6 data",  IW'(out_data[0]),  IW'(0));
        chk("t6 exc",   IW'(out_exc[0]),   IW'(0));
        chk("t6 occ",   IW'(occ[0]),       IW'(0));
        chk("t6 ready", IW'(in_ready[0]),  IW'(1));
        step();
        out_ready[0] = 1'b1;
        idle(2);
        chk_drain(0, "t6 nothing out");

        // SKID=0: streaming
        out_ready[1] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(IW'('h100 + i));
            push(1, DW'('h100 + i), 4'h0);
        end
        idle(3);
        chk_drain(1, "s0 stream order");

        // SKID=0: back-pressure; ready follows out_ready in the same cycle
        out_ready[1] = 1'b0;
        push(1, DW'('hA1), 4'h0);
        in_valid[1] = 1'b1;
        in_data[1]  = DW'('hB2);
        @(negedge clk);
        chk("s0 ready lo", IW'(in_ready[1]), IW'(0));
        chk("s0 occ one",  IW'(occ[1]),      IW'(1));
        step();
        step();
        out_ready[1] = 1'b1;
        @(negedge clk);
        chk("s0 ready follows", IW'(in_ready[1]), IW'(1));
        step();
        in_valid[1] = 1'b0;
        push(1, DW'('hC3), 4'h0);
        idle(3);
        exp_q.push_back(IW'('hA1));
        exp_q.push_back(IW'('hB2));
        exp_q.push_back(IW'('hC3));
        chk_drain(1, "s0 bp order");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
